// File: rtl/barcode_tx.sv
// Barcode line transmitter: start pulse of width T, then 8 pulse-width coded bits.
// Optional BC_TX_IDCHK_EN: reject IDs with tx_ID[7:6] != 2'b00.
module barcode_tx #(
  parameter int TW = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          send,
  input  logic [7:0]    tx_ID,
  input  logic [TW-1:0] bit_time,
  output logic          BC,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE,
    START_LO,
    START_HI,
    BIT_LO,
    BIT_HI
  } state_t;

  state_t        state;
  logic [TW-1:0] t_q;
  logic [TW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;

  logic [TW-1:0] lo1;
  logic [TW-1:0] lo0;
  logic [TW-1:0] two_t;
  logic [TW-1:0] hi1;
  logic [TW-1:0] hi0;
  logic [TW-1:0] lo_cur;
  logic [TW-1:0] lo_nxt;
  logic [TW-1:0] hi_cur;
  logic          bad;

  // Slot is always exactly 2T; odd T truncates the short pulse.
  always_comb begin
    lo1    = t_q >> 1;
    lo0    = t_q + (t_q >> 1);
    two_t  = {t_q[TW-2:0], 1'b0};
    hi1    = two_t - lo1;
    hi0    = two_t - lo0;
    lo_cur = sh[7] ? lo1 : lo0;
    lo_nxt = sh[6] ? lo1 : lo0;
    hi_cur = sh[7] ? hi1 : hi0;
  end

  always_comb begin
    bad = (bit_time < TW'(4));
`ifdef BC_TX_IDCHK_EN
    bad = bad || (tx_ID[7:6] != 2'b00);
`else
    bad = bad;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      BC    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      t_q   <= '0;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (send) begin
            if (bad) begin
              err <= 1'b1;
            end else begin
              t_q   <= bit_time;
              sh    <= tx_ID;
              idx   <= '0;
              cnt   <= bit_time - TW'(1);
              BC    <= 1'b0;
              busy  <= 1'b1;
              state <= START_LO;
            end
          end
        end
        START_LO: begin
          if (cnt == '0) begin
            cnt   <= t_q - TW'(1);
            BC    <= 1'b1;
            state <= START_HI;
          end else begin
            cnt <= cnt - TW'(1);
          end
        end
        START_HI: begin
          if (cnt == '0) begin
            cnt   <= lo_cur - TW'(1);
            BC    <= 1'b0;
            state <= BIT_LO;
          end else begin
            cnt <= cnt - TW'(1);
          end
        end
        BIT_LO: begin
          if (cnt == '0) begin
            cnt   <= hi_cur - TW'(1);
            BC    <= 1'b1;
            state <= BIT_HI;
          end else begin
            cnt <= cnt - TW'(1);
          end
        end
        BIT_HI: begin
          if (cnt == '0) begin
            if (idx == 3'd7) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              idx   <= idx + 3'd1;
              sh    <= {sh[6:0], 1'b0};
              cnt   <= lo_nxt - TW'(1);
              BC    <= 1'b0;
              state <= BIT_LO;
            end
          end else begin
            cnt <= cnt - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barcode_tx.sv
// Directed bench for barcode_tx: frame pulse widths checked against a queue
// of expected low/high run lengths pushed when each send is driven.
module tb_barcode_tx;

  localparam int TW  = 22;
  localparam int LIM = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          send = 1'b0;
  logic [7:0]    tx_ID = '0;
  logic [TW-1:0] bit_time = '0;
  logic          BC;
  logic          busy;
  logic          done;
  logic          err;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];

  barcode_tx #(.TW(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .send     (send),
    .tx_ID    (tx_ID),
    .bit_time (bit_time),
    .BC       (BC),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Push expected frame shape, then pulse send; returns in cycle N+1.
  task automatic start(input logic [7:0] id, input int t);
    int lo;
    exp_q.push_back(18 * t);
    exp_q.push_back(t);
    exp_q.push_back(t);
    for (int b = 7; b >= 0; b--) begin
      lo = id[b] ? (t >> 1) : (t + (t >> 1));
      exp_q.push_back(lo);
      exp_q.push_back(2 * t - lo);
    end
    tx_ID    = id;
    bit_time = TW'(t);
    send     = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  // Measure run lengths of BC while busy; ends in the done cycle.
  task automatic check_frame(input string tag);
    int e_tot, e_lo, e_hi, lo, hi, total;
    e_tot = exp_q.pop_front();
    check({tag, " first_busy"}, {31'd0, busy}, 32'd1);
    check({tag, " first_bc"}, {31'd0, BC}, 32'd0);
    total = 0;
    for (int s = 0; s < 9; s++) begin
      e_lo = exp_q.pop_front();
      e_hi = exp_q.pop_front();
      lo = 0;
      while (BC === 1'b0 && busy === 1'b1 && lo < LIM) begin
        lo++;
        @(negedge clk);
      end
      hi = 0;
      while (BC === 1'b1 && busy === 1'b1 && hi < LIM) begin
        hi++;
        @(negedge clk);
      end
      check($sformatf("%s seg%0d_lo", tag, s), lo, e_lo);
      check($sformatf("%s seg%0d_hi", tag, s), hi, e_hi);
      total += lo + hi;
    end
    check({tag, " busy_len"}, total, e_tot);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " end_busy"}, {31'd0, busy}, 32'd0);
    check({tag, " end_bc"}, {31'd0, BC}, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_bc", {31'd0, BC}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    start(8'h2A, 8);
    check_frame("t8_2a");
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);

    start(8'h01, 9);
    check_frame("t9_01");
    @(negedge clk);

    start(8'hFF, 4);
    check_frame("t4_ff");
    @(negedge clk);

    start(8'h55, 8);
    fork
      check_frame("ign_55");
      begin
        repeat (20) @(negedge clk);
        tx_ID    = 8'hAA;
        bit_time = TW'(6);
        send     = 1'b1;
        @(negedge clk);
        send = 1'b0;
      end
    join
    // Back-to-back: send in the done cycle
    start(8'h3F, 16);
    check_frame("b2b_3f");
    start(8'h15, 5);
    check_frame("b2b_15");
    @(negedge clk);

    start(8'h2A, 8);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_bc", {31'd0, BC}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    repeat (200) @(negedge clk);
    check("abort_nodone", {31'd0, done}, 32'd0);
    start(8'hC3, 8);
    check_frame("after_abort");
    @(negedge clk);

    tx_ID    = 8'h11;
    bit_time = TW'(8);
    rst      = 1'b1;
    send     = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    send = 1'b0;
    check("rst_send_busy", {31'd0, busy}, 32'd0);
    check("rst_send_bc", {31'd0, BC}, 32'd1);
    @(negedge clk);

    tx_ID    = 8'h00;
    bit_time = TW'(3);
    send     = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("t3_err", {31'd0, err}, 32'd1);
    check("t3_bc", {31'd0, BC}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t3_err_clr", {31'd0, err}, 32'd0);
    check("t3_bc2", {31'd0, BC}, 32'd1);

`ifdef BC_TX_IDCHK_EN
    tx_ID    = 8'h80;
    bit_time = TW'(5);
    send     = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("id80_err", {31'd0, err}, 32'd1);
    check("id80_busy", {31'd0, busy}, 32'd0);
    check("id80_bc", {31'd0, BC}, 32'd1);
    @(negedge clk);
    check("id80_err_clr", {31'd0, err}, 32'd0);
`else
    start(8'h80, 5);
    check("id80_err", {31'd0, err}, 32'd0);
    check_frame("id80");
`endif
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
